dvp_pixel_packer: RTL and testbench

- Capture front-end of the DVP RX path. It consumes the capture-enable bit from the DVP configuration register.
- It samples the camera byte stream (vsync/href/data, already synchronised to clk, one pclk_en strobe per byte) and frames it.
- It packs bytes into 32-bit words and delivers them through an internal FIFO on a valid/ready stream toward the DMA/AXI write stage, with end-of-frame marking and overflow status.

---
 rtl/dvp_rx_pkg.sv | 17 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/dvp_pixel_packer.sv | 184 ++++++++++++++++++
 tb/tb_dvp_pixel_packer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_rx_pkg.sv
// dvp_rx_pkg: shared types and constants for the DVP receive path
package dvp_rx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACTIVE   = 2'd2,
        DROP     = 2'd3
    } state_t;

    localparam int CFG_CAP_EN_BIT = 0;

    function automatic int bytes_per_word(input int data_w, input int pxl_w);
        return data_w / pxl_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with full/empty flags
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             we, re;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    // accept a write when there is room or the head leaves in the same cycle
    always_comb begin
        we   = push_i & (~full_o | pop_i);
        re   = pop_i & ~empty_o;
        wr_d = wr_q + {{AW{1'b0}}, we};
        rd_d = rd_q + {{AW{1'b0}}, re};
    end

    // pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // storage array, contents are only observed behind the empty flag
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/dvp_pixel_packer.sv
// dvp_pixel_packer: frames the DVP byte stream and packs bytes into FIFO-buffered words
module dvp_pixel_packer
    import dvp_rx_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PXL_W      = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int LINE_CNT_W = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cap_en_i,
    input  logic                  dvp_pclk_en_i,
    input  logic                  dvp_vsync_i,
    input  logic                  dvp_href_i,
    input  logic [PXL_W-1:0]      dvp_d_i,
    output logic [DATA_W-1:0]     pxl_data_o,
    output logic                  pxl_last_o,
    output logic                  pxl_valid_o,
    input  logic                  pxl_ready_i,
    output logic                  frame_done_o,
    output logic                  ovf_o,
    output logic [LINE_CNT_W-1:0] line_cnt_o
);

    localparam int BPW = bytes_per_word(DATA_W, PXL_W);
    localparam int IW  = $clog2(BPW);

    state_t                state_q, state_d;
    logic                  vs_q, vs_d, hr_q, hr_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_W-1:0]     acc_q, acc_d, stg_q, stg_d, pad, push_word;
    logic                  cmp_q, cmp_d, stg_v_q, stg_v_d, fin_q, fin_d;
    logic                  done_q, done_d, ovf_q, ovf_d;
    logic [LINE_CNT_W-1:0] line_q, line_d;
    logic                  pe, sof, eof, eol, push, push_last, pop, ovf_ev, full, empty;
    logic [DATA_W:0]       fifo_dout;

    // the second write of a two-word flush blocks sampling for that cycle
    assign pe  = dvp_pclk_en_i & ~fin_q;
    assign sof = pe & vs_q & ~dvp_vsync_i;
    assign eof = pe & ~vs_q & dvp_vsync_i;
    assign eol = pe & hr_q & ~dvp_href_i;
    assign pop = ~empty & pxl_ready_i;

    // partial word with the lanes not yet written forced to zero
    always_comb begin
        pad = '0;
        for (int i = 0; i < BPW; i++)
            pad[i*PXL_W +: PXL_W] = (i < int'(idx_q)) ? acc_q[i*PXL_W +: PXL_W] : '0;
    end

    // framing FSM, byte packing, staging, flush and overflow handling
    always_comb begin
        state_d   = state_q;
        vs_d      = pe ? dvp_vsync_i : vs_q;
        hr_d      = pe ? dvp_href_i : hr_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        cmp_d     = cmp_q;
        stg_d     = stg_q;
        stg_v_d   = stg_v_q;
        fin_d     = fin_q;
        done_d    = 1'b0;
        line_d    = line_q;
        push      = 1'b0;
        push_word = stg_q;
        push_last = 1'b0;
        unique case (state_q)
            IDLE: state_d = cap_en_i ? WAIT_SOF : IDLE;
            WAIT_SOF: begin
                if (!cap_en_i) begin
                    state_d = IDLE;
                end else if (sof) begin
                    state_d = ACTIVE;
                    line_d  = '0;
                end
            end
            ACTIVE: begin
                if (eof) begin
                    state_d = cap_en_i ? WAIT_SOF : IDLE;
                    idx_d   = '0;
                    cmp_d   = 1'b0;
                    if (stg_v_q && (cmp_q || idx_q != '0)) begin
                        push    = 1'b1;
                        stg_d   = cmp_q ? acc_q : pad;
                        stg_v_d = 1'b1;
                        fin_d   = 1'b1;
                    end else begin
                        push      = cmp_q || idx_q != '0 || stg_v_q;
                        push_word = cmp_q ? acc_q : (idx_q != '0) ? pad : stg_q;
                        push_last = 1'b1;
                        stg_v_d   = 1'b0;
                        done_d    = 1'b1;
                    end
                end else begin
                    if (cmp_q) begin
                        push    = stg_v_q;
                        stg_d   = acc_q;
                        stg_v_d = 1'b1;
                        cmp_d   = 1'b0;
                    end
                    if (pe && dvp_href_i) begin
                        acc_d[idx_q*PXL_W +: PXL_W] = dvp_d_i;
                        idx_d = (idx_q == IW'(BPW-1)) ? '0 : idx_q + 1'b1;
                        cmp_d = (idx_q == IW'(BPW-1));
                    end
                    if (eol) line_d = (&line_q) ? line_q : line_q + 1'b1;
                end
            end
            DROP: if (eof) state_d = cap_en_i ? WAIT_SOF : IDLE;
        endcase
        if (fin_q) begin
            push      = 1'b1;
            push_last = 1'b1;
            stg_v_d   = 1'b0;
            fin_d     = 1'b0;
            done_d    = 1'b1;
        end
        ovf_ev = push & full & ~pop;
        if (ovf_ev) begin
            done_d  = 1'b0;
            stg_v_d = 1'b0;
            idx_d   = '0;
            cmp_d   = 1'b0;
            fin_d   = 1'b0;
            if (state_d == ACTIVE) state_d = DROP;
        end
        ovf_d = ovf_ev | (ovf_q & cap_en_i);
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vs_q    <= 1'b0;
            hr_q    <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            cmp_q   <= 1'b0;
            stg_q   <= '0;
            stg_v_q <= 1'b0;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= vs_d;
            hr_q    <= hr_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cmp_q   <= cmp_d;
            stg_q   <= stg_d;
            stg_v_q <= stg_v_d;
            fin_q   <= fin_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            line_q  <= line_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   ({push_last, push_word}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty)
    );

    assign pxl_valid_o  = ~empty;
    assign pxl_data_o   = empty ? '0 : fifo_dout[DATA_W-1:0];
    assign pxl_last_o   = ~empty & fifo_dout[DATA_W];
    assign frame_done_o = done_q;
    assign ovf_o        = ovf_q;
    assign line_cnt_o   = line_q;

endmodule

// File: tb/tb_dvp_pixel_packer.sv
// tb_dvp_pixel_packer: directed and randomized frames checked against a byte-packing model
module tb_dvp_pixel_packer;
    import dvp_rx_pkg::*;

    logic        clk = 0, rst_n = 0, cap_en = 0, pclk_en = 0, vsync = 0, href = 0, ready = 0;
    logic [7:0]  din = 0;
    logic [31:0] pdata;
    logic        plast, pvalid, fdone, ovf;
    logic [11:0] lcnt;

    int          errors = 0, checks = 0, done_cnt = 0, rdy_mode = 1, d0 = 0, nl = 0;
    logic [32:0] got_q[$], exp_q[$];
    logic [7:0]  fb[$];
    int          ll[$];

    always #5 clk = ~clk;

    dvp_pixel_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cap_en_i      (cap_en),
        .dvp_pclk_en_i (pclk_en),
        .dvp_vsync_i   (vsync),
        .dvp_href_i    (href),
        .dvp_d_i       (din),
        .pxl_data_o    (pdata),
        .pxl_last_o    (plast),
        .pxl_valid_o   (pvalid),
        .pxl_ready_i   (ready),
        .frame_done_o  (fdone),
        .ovf_o         (ovf),
        .line_cnt_o    (lcnt)
    );

    // downstream ready: held low, held high, or random per cycle
    initial forever begin
        @(posedge clk); #1;
        ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : rdy_mode[0];
    end

    // collect accepted words and frame_done pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (pvalid && ready) got_q.push_back({plast, pdata});
            if (fdone) done_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pb(input logic v, input logic h, input logic [7:0] d);
        pclk_en = 1; vsync = v; href = h; din = d;
        @(posedge clk); #1;
        pclk_en = 0;
        @(posedge clk); #1;
    endtask

    task automatic new_frame();
        fb.delete();
        ll.delete();
    endtask

    task automatic mk_line(input int len, input int start, input bit rnd);
        ll.push_back(len);
        for (int j = 0; j < len; j++) fb.push_back(rnd ? 8'($urandom) : 8'(start + j));
    endtask

    // reference: bytes little-endian into words, zero padded, last flag on the final word
    task automatic expect_frame();
        logic [31:0] w;
        for (int i = 0; i < fb.size(); i += 4) begin
            w = '0;
            for (int j = 0; j < 4; j++) if (i + j < fb.size()) w[j*8 +: 8] = fb[i+j];
            exp_q.push_back({(i + 4 >= fb.size()), w});
        end
    endtask

    // blanking, SOF, lines each ending in EOL, EOF; cap_en toggles before line tl
    task automatic send_frame(input int tl);
        int k = 0;
        pb(1, 0, 0); pb(1, 0, 0); pb(0, 0, 0); pb(0, 0, 0);
        for (int l = 0; l < ll.size(); l++) begin
            if (l == tl) cap_en = ~cap_en;
            for (int j = 0; j < ll[l]; j++) begin
                pb(0, 1, fb[k]);
                k++;
            end
            pb(0, 0, 0); pb(0, 0, 0);
        end
        pb(1, 0, 0); pb(1, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (pvalid && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_bound", 64'(n < 500), 64'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic cmp_frames(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(pvalid), 0);
        chk("rst_data", 64'(pdata), 0);
        chk("rst_last", 64'(plast), 0);
        chk("rst_done", 64'(fdone), 0);
        chk("rst_ovf", 64'(ovf), 0);
        chk("rst_lcnt", 64'(lcnt), 0);
        chk("rst_state", 64'(dut.state_q), 64'(IDLE));
        rst_n = 1;
        cap_en = 1;
        rdy_mode = 1;

        // one line of 0x01..0x08
        new_frame(); mk_line(8, 1, 0); expect_frame();
        d0 = done_cnt;
        send_frame(-1); drain();
        cmp_frames("t1");
        chk("t1_done", 64'(done_cnt - d0), 1);
        chk("t1_lcnt", 64'(lcnt), 1);

        // 6 bytes 0xA1..0xA6: padded final word
        new_frame(); mk_line(6, 8'hA1, 0); expect_frame();
        d0 = done_cnt;
        send_frame(-1); drain();
        cmp_frames("t2");
        chk("t2_done", 64'(done_cnt - d0), 1);

        // enable arrives mid-frame: frame skipped, next one captured
        cap_en = 0;
        repeat (2) @(posedge clk);
        #1;
        new_frame(); mk_line(5, 0, 1); mk_line(7, 0, 1); mk_line(4, 0, 1);
        d0 = done_cnt;
        send_frame(1); drain();
        cmp_frames("t3_skip");
        chk("t3_skip_done", 64'(done_cnt - d0), 0);
        new_frame(); mk_line(9, 0, 1); mk_line(3, 0, 1); mk_line(12, 0, 1); expect_frame();
        d0 = done_cnt;
        send_frame(-1); drain();
        cmp_frames("t3_next");
        chk("t3_next_done", 64'(done_cnt - d0), 1);
        chk("t3_next_lcnt", 64'(lcnt), 3);

        // random frames with random backpressure
        rdy_mode = 2;
        for (int f = 0; f < 4; f++) begin
            new_frame();
            nl = int'($urandom_range(1, 4));
            for (int l = 0; l < nl; l++) mk_line(int'($urandom_range(1, 16)), 0, 1);
            expect_frame();
            d0 = done_cnt;
            send_frame(-1); drain();
            cmp_frames($sformatf("rnd%0d", f));
            chk($sformatf("rnd%0d_done", f), 64'(done_cnt - d0), 1);
            chk($sformatf("rnd%0d_lcnt", f), 64'(lcnt), 64'(nl));
        end

        // no ready, 40-byte frame: first FIFO_DEPTH words kept, overflow
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        new_frame(); mk_line(40, 0, 1); expect_frame();
        while (exp_q.size() > 8) void'(exp_q.pop_back());
        d0 = done_cnt;
        send_frame(-1);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_ovf", 64'(ovf), 1);
        chk("t4_done", 64'(done_cnt - d0), 0);
        chk("t4_valid", 64'(pvalid), 1);
        rdy_mode = 1;
        drain();
        cmp_frames("t4");
        chk("t4_ovf_sticky", 64'(ovf), 1);
        cap_en = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("t4_ovf_clr", 64'(ovf), 0);

        // disable after two of four lines: frame completes, then idle
        cap_en = 1;
        repeat (2) @(posedge clk);
        #1;
        new_frame();
        for (int l = 0; l < 4; l++) mk_line(int'($urandom_range(1, 10)), 0, 1);
        expect_frame();
        d0 = done_cnt;
        send_frame(2); drain();
        cmp_frames("t5");
        chk("t5_done", 64'(done_cnt - d0), 1);
        chk("t5_lcnt", 64'(lcnt), 4);
        chk("t5_state", 64'(dut.state_q), 64'(IDLE));
        new_frame(); mk_line(8, 0, 1); mk_line(8, 0, 1);
        d0 = done_cnt;
        send_frame(-1); drain();
        cmp_frames("t5_off");
        chk("t5_off_done", 64'(done_cnt - d0), 0);
        chk("t5_off_lcnt", 64'(lcnt), 4);

        // reset mid-line with FIFO partly filled
        cap_en = 1;
        rdy_mode = 0;
        pb(1, 0, 0); pb(1, 0, 0); pb(0, 0, 0);
        for (int j = 0; j < 8; j++) pb(0, 1, 8'($urandom));
        pb(0, 0, 0);
        for (int j = 0; j < 12; j++) pb(0, 1, 8'($urandom));
        chk("t6_pre_lcnt", 64'(lcnt), 1);
        chk("t6_pre_valid", 64'(pvalid), 1);
        rst_n = 0;
        @(negedge clk);
        chk("t6_valid", 64'(pvalid), 0);
        chk("t6_ovf", 64'(ovf), 0);
        chk("t6_lcnt", 64'(lcnt), 0);
        chk("t6_state", 64'(dut.state_q), 64'(IDLE));
        @(posedge clk); #1;
        href = 0;
        rst_n = 1;
        rdy_mode = 1;
        got_q.delete();
        new_frame(); mk_line(11, 0, 1); mk_line(6, 0, 1); expect_frame();
        d0 = done_cnt;
        send_frame(-1); drain();
        cmp_frames("t6_after");
        chk("t6_after_done", 64'(done_cnt - d0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
